// File: rtl/display_pkg.sv
// Shared widths and seven-segment patterns for the front-panel display driver.
package display_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned BCD_W = 4;

  // Segment patterns, active-high, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to seven-segment decoder; non-decimal codes show a dash.
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [SEG_W-1:0] seg_o
);

  // Pattern lookup; 10..15 fall through to the dash so bad codes are visible
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_7seg_scan.sv
// Time-multiplexed seven-segment scanner with frame-synchronous digit update,
// leading-zero blanking, per-digit blinking and selectable output polarity.
module display_7seg_scan
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BCD_W*NUM_DIGITS-1:0]   digits_i,
  input  logic                          load_i,
  input  logic                          blank_lz_i,
  input  logic                          blink_en_i,
  input  logic [NUM_DIGITS-1:0]         blink_mask_i,
  input  logic [NUM_DIGITS-1:0]         dp_mask_i,
  output logic [SEG_W-1:0]              seg_o,
  output logic                          dp_o,
  output logic [NUM_DIGITS-1:0]         an_o,
  output logic                          frame_tick_o
);

  localparam int unsigned DATA_W = BCD_W * NUM_DIGITS;
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam int unsigned RC_W   = $clog2(REFRESH_DIV);
  localparam int unsigned FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REFRESH_DIV - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

  // Pin levels meaning "nothing lit" for the selected polarity
  localparam logic [SEG_W-1:0]      SEG_OFF = ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic                  DP_OFF  = ACTIVE_LOW;

  logic [RC_W-1:0]   refresh_cnt_q, refresh_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic [DATA_W-1:0] pending_q, pending_d;
  logic [DATA_W-1:0] active_q, active_d;
  logic              frame_tick_q, frame_tick_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                              wrap;
  logic [NUM_DIGITS-1:0][BCD_W-1:0]  disp_digits;
  logic [BCD_W-1:0]                  cur_bcd;
  logic [SEG_W-1:0]                  dec_seg;
  logic [NUM_DIGITS-1:0]             lz_mask;
  logic                              lz_run;
  logic                              blank_cur;
  logic [SEG_W-1:0]                  seg_act;
  logic                              dp_act;
  logic [NUM_DIGITS-1:0]             an_act;

  // Refresh divider, digit index, and blink frame counter
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + RC_W'(1);
    idx_d         = idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    wrap          = 1'b0;
    if (refresh_cnt_q == RC_LAST) begin
      refresh_cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        wrap  = 1'b1;
        if (frame_cnt_q == FC_LAST) begin
          frame_cnt_d   = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          frame_cnt_d = frame_cnt_q + FC_W'(1);
        end
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  assign frame_tick_d = wrap;

  // Double buffer: active only changes in the frame-tick cycle, which is also
  // the cycle that renders digit 0, so the incoming value is shown from there.
  always_comb begin
    pending_d = load_i ? digits_i : pending_q;
    active_d  = active_q;
    if (frame_tick_q) begin
      active_d = load_i ? digits_i : pending_q;
    end
  end

  assign disp_digits = active_d;
  assign cur_bcd     = disp_digits[idx_q];

  bcd_to_7seg u_dec (
    .bcd_i (cur_bcd),
    .seg_o (dec_seg)
  );

  // Leading-zero run from the top digit down; digit 0 is never part of it
  always_comb begin
    lz_run  = 1'b1;
    lz_mask = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      lz_run                = lz_run & (disp_digits[IDX_W'(i)] == '0);
      lz_mask[IDX_W'(i)]    = lz_run;
    end
  end

  // Per-digit blanking, decimal point and anode select, then output polarity
  always_comb begin
    blank_cur = (blank_lz_i & lz_mask[idx_q])
              | (blink_en_i & ~blink_phase_q & blink_mask_i[idx_q]);
    seg_act   = blank_cur ? SEG_BLANK : dec_seg;
    dp_act    = dp_mask_i[idx_q] & ~blank_cur;
    an_act    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    seg_d     = ACTIVE_LOW ? ~seg_act : seg_act;
    dp_d      = ACTIVE_LOW ? ~dp_act  : dp_act;
    an_d      = ACTIVE_LOW ? ~an_act  : an_act;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt_q <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      pending_q     <= '0;
      active_q      <= '0;
      frame_tick_q  <= 1'b0;
      seg_q         <= SEG_OFF;
      dp_q          <= DP_OFF;
      an_q          <= AN_OFF;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      pending_q     <= pending_d;
      active_q      <= active_d;
      frame_tick_q  <= frame_tick_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
    end
  end

  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign an_o         = an_q;
  assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_display_7seg_scan.sv
// Directed bench for display_7seg_scan: 4 digits, 4-cycle refresh, 2-frame blink, active-low pins.
module tb_display_7seg_scan;

  localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F, S4 = 7'h66;
  localparam logic [6:0] S5 = 7'h6D, S6 = 7'h7D, S7 = 7'h07, S8 = 7'h7F, S9 = 7'h6F;
  localparam logic [6:0] SD = 7'h40, SB = 7'h00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits_i;
  logic        load_i, blank_lz_i, blink_en_i;
  logic [3:0]  blink_mask_i, dp_mask_i;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        frame_tick_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0]     digits;
    logic            blz;
    logic [3:0]      dp;
    logic [3:0][6:0] seg;   // expected active-high pattern, [0] = rightmost digit
    logic [3:0]      edp;   // expected active-high decimal points
  } vec_t;

  vec_t vecs[8];

  display_7seg_scan #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLINK_FRAMES(2),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .digits_i     (digits_i),
    .load_i       (load_i),
    .blank_lz_i   (blank_lz_i),
    .blink_en_i   (blink_en_i),
    .blink_mask_i (blink_mask_i),
    .dp_mask_i    (dp_mask_i),
    .seg_o        (seg_o),
    .dp_o         (dp_o),
    .an_o         (an_o),
    .frame_tick_o (frame_tick_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc%0d: got %0h want %0h", nm, n, act, exp);
    end
  endtask

  task automatic check_off(input string nm);
    chk({nm, ".seg"},  0, 32'(seg_o), 32'h7F);
    chk({nm, ".an"},   0, 32'(an_o), 32'hF);
    chk({nm, ".dp"},   0, 32'(dp_o), 32'h1);
    chk({nm, ".tick"}, 0, 32'(frame_tick_o), 32'h0);
  endtask

  // Checks one 16-cycle frame starting at the edge after a frame tick.
  // Optionally pulses load_i right after sample ld_at.
  task automatic check_frame(input string nm, input logic [3:0][6:0] es, input logic [3:0] ed,
                             input int ld_at, input logic [15:0] ld_val);
    int         k;
    logic [3:0] an_exp;
    logic [6:0] seg_exp;
    logic       dp_exp;
    logic       tick_exp;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      load_i   = 1'b0;
      k        = (n - 1) / 4;
      an_exp   = ~(4'b0001 << k);
      seg_exp  = ~es[k];
      dp_exp   = ~ed[k];
      tick_exp = (n == 16);
      chk({nm, ".an"},   n, 32'(an_o), 32'(an_exp));
      chk({nm, ".seg"},  n, 32'(seg_o), 32'(seg_exp));
      chk({nm, ".dp"},   n, 32'(dp_o), 32'(dp_exp));
      chk({nm, ".tick"}, n, 32'(frame_tick_o), 32'(tick_exp));
      if (n == ld_at) begin
        load_i   = 1'b1;
        digits_i = ld_val;
      end
    end
  endtask

  task automatic wait_tick(input string nm);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      load_i = 1'b0;
      if (frame_tick_o) seen = 1'b1;
    end
    chk({nm, ".tick_wait"}, 0, 32'(seen), 32'h1);
  endtask

  initial begin
    rst_n        = 1'b0;
    digits_i     = '0;
    load_i       = 1'b0;
    blank_lz_i   = 1'b0;
    blink_en_i   = 1'b0;
    blink_mask_i = '0;
    dp_mask_i    = '0;

    vecs[0] = '{16'h0130, 1'b0, 4'b0000, {S0, S1, S3, S0}, 4'b0000};
    vecs[1] = '{16'h0009, 1'b1, 4'b0000, {SB, SB, SB, S9}, 4'b0000};
    vecs[2] = '{16'h0000, 1'b1, 4'b0000, {SB, SB, SB, S0}, 4'b0000};
    vecs[3] = '{16'h00C0, 1'b0, 4'b0000, {S0, S0, SD, S0}, 4'b0000};
    vecs[4] = '{16'h0102, 1'b1, 4'b1110, {SB, S1, S0, S2}, 4'b0110};
    vecs[5] = '{16'h8765, 1'b1, 4'b0001, {S8, S7, S6, S5}, 4'b0001};
    vecs[6] = '{16'h0090, 1'b1, 4'b1111, {SB, SB, S9, S0}, 4'b0011};
    vecs[7] = '{16'h4F2A, 1'b0, 4'b0000, {S4, SD, S2, SD}, 4'b0000};

    // Reset state, then first edge after release shows "0" on digit 0
    repeat (3) @(negedge clk);
    check_off("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("first.an",   1, 32'(an_o), 32'hE);
    chk("first.seg",  1, 32'(seg_o), 32'h40);
    chk("first.dp",   1, 32'(dp_o), 32'h1);
    chk("first.tick", 1, 32'(frame_tick_o), 32'h0);

    // Static patterns, each checked over a whole frame
    for (int i = 0; i < 8; i++) begin
      blank_lz_i = vecs[i].blz;
      dp_mask_i  = vecs[i].dp;
      digits_i   = vecs[i].digits;
      load_i     = 1'b1;
      @(negedge clk);
      load_i = 1'b0;
      wait_tick($sformatf("v%0d", i));
      check_frame($sformatf("v%0d", i), vecs[i].seg, vecs[i].edp, 0, 16'h0);
    end

    // Mid-frame load waits for the next frame; load in the tick cycle bypasses
    check_frame("mid_old", vecs[7].seg, 4'b0000, 6, 16'h0159);
    check_frame("mid_new", {S0, S1, S5, S9}, 4'b0000, 16, 16'h0246);
    check_frame("bypass",  {S0, S2, S4, S6}, 4'b0000, 0, 16'h0);

    // Reset mid-frame with a pending load: outputs off at once, load discarded
    repeat (5) @(negedge clk);
    digits_i = 16'h0777;
    load_i   = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_off("rst_mid");
    @(negedge clk);
    check_off("rst_hold");
    rst_n = 1'b1;
    check_frame("post_rst0", {S0, S0, S0, S0}, 4'b0000, 0, 16'h0);
    check_frame("post_rst1", {S0, S0, S0, S0}, 4'b0000, 0, 16'h0);

    // Blink: phase starts visible, toggles every 2 frames counted from reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n        = 1'b1;
    digits_i     = 16'h1234;
    load_i       = 1'b1;
    blank_lz_i   = 1'b0;
    dp_mask_i    = 4'b1111;
    blink_en_i   = 1'b1;
    blink_mask_i = 4'b1100;
    @(negedge clk);
    load_i = 1'b0;
    wait_tick("blink");
    check_frame("blink_f1", {S1, S2, S3, S4}, 4'b1111, 0, 16'h0);
    check_frame("blink_f2", {SB, SB, S3, S4}, 4'b0011, 0, 16'h0);
    check_frame("blink_f3", {SB, SB, S3, S4}, 4'b0011, 0, 16'h0);
    check_frame("blink_f4", {S1, S2, S3, S4}, 4'b1111, 0, 16'h0);
    blink_en_i = 1'b0;
    check_frame("blink_f5", {S1, S2, S3, S4}, 4'b1111, 0, 16'h0);
    check_frame("blink_off", {S1, S2, S3, S4}, 4'b1111, 0, 16'h0);
    blink_en_i = 1'b1;
    check_frame("blink_f7", {SB, SB, S3, S4}, 4'b0011, 0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
